mod_counter: RTL and testbench

Parametrised synchronous up/down modulo counter. It replaces the fixed 8-bit free-running counter wherever the design needs a programmable count range, direction control, load/clear, a prescaler, wrap/saturate selection and terminal-count/overflow flags. It sits alongside the CNN datapath as the common building block for loop indices, address sequencing and event timing.

---
 rtl/mod_counter.sv | 129 ++++++++++++
 tb/tb_mod_counter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// mod_counter: parametrised up/down modulo counter with prescaler,
// load/clear, wrap/saturate selection, terminal-count and overflow flags.
module mod_counter #(
    parameter int WIDTH    = 8,
    parameter int MAX      = (2 ** WIDTH) - 1,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] L_MAX     = WIDTH'(MAX);
    localparam logic [PW-1:0]    L_PS_LAST = PW'(PRESCALE - 1);
    localparam logic             L_SAT     = (SATURATE != 0);

    logic [WIDTH-1:0] r_out;
    logic [PW-1:0]    r_ps;
    logic             r_wrap;
    logic             r_ovf;

    logic             w_at_max;
    logic             w_at_zero;
    logic             w_term;
    logic             w_ps_last;
    logic             w_step;
    logic             w_hold;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_step_val;

    // Terminal detection and step-fire qualification
    always_comb begin
        w_at_max  = (r_out == L_MAX);
        w_at_zero = (r_out == '0);
        w_term    = up ? w_at_max : w_at_zero;
        w_ps_last = (r_ps == L_PS_LAST);
        w_hold    = clear | load;
        w_step    = en & w_ps_last & ~w_hold;
    end

    // Load value clamped into 0..MAX; extra bit keeps the compare non-trivial
    always_comb begin
        w_load_clamped = load_val;
        if ({1'b0, load_val} > {1'b0, L_MAX}) begin
            w_load_clamped = L_MAX;
        end
    end

    // Next count for a fired step: wrap or saturate at the terminal value
    always_comb begin
        w_step_val = r_out;
        if (up) begin
            if (w_at_max) begin
                w_step_val = L_SAT ? L_MAX : '0;
            end else begin
                w_step_val = r_out + WIDTH'(1);
            end
        end else begin
            if (w_at_zero) begin
                w_step_val = L_SAT ? '0 : L_MAX;
            end else begin
                w_step_val = r_out - WIDTH'(1);
            end
        end
    end

    // Prescaler: advances on enabled cycles, zeroed by reset/clear/load
    always_ff @(posedge clk) begin
        if (reset || w_hold) begin
            r_ps <= '0;
        end else if (en) begin
            if (w_ps_last) begin
                r_ps <= '0;
            end else begin
                r_ps <= r_ps + PW'(1);
            end
        end
    end

    // Count register: clear beats load, load beats a due step
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= '0;
        end else if (clear) begin
            r_out <= '0;
        end else if (load) begin
            r_out <= w_load_clamped;
        end else if (w_step) begin
            r_out <= w_step_val;
        end
    end

    // Wrap pulse: high only after a step attempted from a terminal value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_step & w_term;
        end
    end

    // Sticky overflow: a new wrap event wins over ovf_clr
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_step && w_term) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign out  = r_out;
    assign tc   = w_term;
    assign wrap = r_wrap;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: five differently parametrised counters share one stimulus
// stream; a modulo-arithmetic model predicts every output each cycle.
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       ovf_clr = 1'b0;

    logic [7:0] o_out0;
    logic [3:0] o_out1;
    logic [3:0] o_out2;
    logic [7:0] o_out3;
    logic [0:0] o_out4;
    logic [4:0] o_tc;
    logic [4:0] o_wrap;
    logic [4:0] o_ovf;

    int c_w[5]   = '{8, 4, 4, 8, 1};
    int c_max[5] = '{255, 9, 9, 99, 0};
    int c_ps[5]  = '{1, 1, 1, 3, 1};
    int c_sat[5] = '{0, 0, 1, 0, 0};

    int m_out[5];
    int m_ps[5];
    int m_wrap[5];
    int m_ovf[5];

    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    mod_counter #(.WIDTH(8), .MAX(255), .PRESCALE(1), .SATURATE(0)) u0 (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear),
        .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
        .out(o_out0), .tc(o_tc[0]), .wrap(o_wrap[0]), .ovf(o_ovf[0])
    );
    mod_counter #(.WIDTH(4), .MAX(9), .PRESCALE(1), .SATURATE(0)) u1 (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear),
        .load(load), .load_val(load_val[3:0]), .ovf_clr(ovf_clr),
        .out(o_out1), .tc(o_tc[1]), .wrap(o_wrap[1]), .ovf(o_ovf[1])
    );
    mod_counter #(.WIDTH(4), .MAX(9), .PRESCALE(1), .SATURATE(1)) u2 (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear),
        .load(load), .load_val(load_val[3:0]), .ovf_clr(ovf_clr),
        .out(o_out2), .tc(o_tc[2]), .wrap(o_wrap[2]), .ovf(o_ovf[2])
    );
    mod_counter #(.WIDTH(8), .MAX(99), .PRESCALE(3), .SATURATE(0)) u3 (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear),
        .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
        .out(o_out3), .tc(o_tc[3]), .wrap(o_wrap[3]), .ovf(o_ovf[3])
    );
    mod_counter #(.WIDTH(1), .MAX(0), .PRESCALE(1), .SATURATE(0)) u4 (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear),
        .load(load), .load_val(load_val[0:0]), .ovf_clr(ovf_clr),
        .out(o_out4), .tc(o_tc[4]), .wrap(o_wrap[4]), .ovf(o_ovf[4])
    );

    function automatic logic [31:0] act_out(int k);
        case (k)
            0: return 32'(o_out0);
            1: return 32'(o_out1);
            2: return 32'(o_out2);
            3: return 32'(o_out3);
            default: return 32'(o_out4);
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: count range is a ring of MAX+1 values
    always @(posedge clk) begin : mdl
        int  lv;
        bit  term;
        for (int k = 0; k < 5; k++) begin
            lv = int'(load_val) % (1 << c_w[k]);
            if (reset) begin
                m_out[k] = 0;
                m_ps[k] = 0;
                m_wrap[k] = 0;
                m_ovf[k] = 0;
            end else begin
                if (ovf_clr) m_ovf[k] = 0;
                m_wrap[k] = 0;
                if (clear) begin
                    m_out[k] = 0;
                    m_ps[k] = 0;
                end else if (load) begin
                    m_out[k] = (lv > c_max[k]) ? c_max[k] : lv;
                    m_ps[k] = 0;
                end else if (en) begin
                    m_ps[k] = m_ps[k] + 1;
                    if (m_ps[k] == c_ps[k]) begin
                        m_ps[k] = 0;
                        term = up ? (m_out[k] == c_max[k]) : (m_out[k] == 0);
                        if (term) begin
                            m_wrap[k] = 1;
                            m_ovf[k] = 1;
                        end
                        if (!(term && c_sat[k] != 0)) begin
                            if (up)
                                m_out[k] = (m_out[k] + 1) % (c_max[k] + 1);
                            else
                                m_out[k] = (m_out[k] + c_max[k]) % (c_max[k] + 1);
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all instances against the model
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("u%0d.out", k), act_out(k), 32'(m_out[k]));
                chk($sformatf("u%0d.tc", k), 32'(o_tc[k]),
                    32'(up ? (m_out[k] == c_max[k]) : (m_out[k] == 0)));
                chk($sformatf("u%0d.wrap", k), 32'(o_wrap[k]), 32'(m_wrap[k]));
                chk($sformatf("u%0d.ovf", k), 32'(o_ovf[k]), 32'(m_ovf[k]));
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        step(1);
        chk_on = 1'b1;
        step(1);
        chk("rst.out", 32'(o_out0), 0);
        chk("rst.ovf", 32'(o_ovf[0]), 0);
        chk("rst.wrap", 32'(o_wrap[0]), 0);

        // Full-range wrap count
        reset = 1'b0; en = 1'b1; up = 1'b1;
        step(255);
        chk("t1.out255", 32'(o_out0), 255);
        chk("t1.tc255", 32'(o_tc[0]), 1);
        chk("t1.wrap255", 32'(o_wrap[0]), 0);
        chk("t1.ovf255", 32'(o_ovf[0]), 0);
        step(1);
        chk("t1.out0", 32'(o_out0), 0);
        chk("t1.wrapped", 32'(o_wrap[0]), 1);
        chk("t1.ovf_set", 32'(o_ovf[0]), 1);
        step(1);
        chk("t1.out1", 32'(o_out0), 1);
        chk("t1.wrap_done", 32'(o_wrap[0]), 0);
        step(2);
        chk("t1.out3", 32'(o_out0), 3);
        chk("t1.ovf_sticky", 32'(o_ovf[0]), 1);

        // Down count through zero, MAX=9
        en = 1'b0; up = 1'b0; load = 1'b1; load_val = 8'd3;
        step(1);
        load = 1'b0;
        chk("t2.load3", 32'(o_out1), 3);
        en = 1'b1;
        step(1); chk("t2.out2", 32'(o_out1), 2);
        step(1); chk("t2.out1", 32'(o_out1), 1);
        step(1); chk("t2.out0", 32'(o_out1), 0);
        chk("t2.tc0", 32'(o_tc[1]), 1);
        step(1); chk("t2.out9", 32'(o_out1), 9);
        chk("t2.wrap", 32'(o_wrap[1]), 1);
        step(1); chk("t2.out8", 32'(o_out1), 8);
        chk("t2.wrap_end", 32'(o_wrap[1]), 0);

        // Saturate at MAX, then reverse
        en = 1'b0; up = 1'b1; load = 1'b1; load_val = 8'd7;
        step(1);
        load = 1'b0; en = 1'b1;
        step(1); chk("t3.out8", 32'(o_out2), 8);
        step(1); chk("t3.out9", 32'(o_out2), 9);
        chk("t3.wrap9", 32'(o_wrap[2]), 0);
        step(1); chk("t3.hold9a", 32'(o_out2), 9);
        chk("t3.wrap_a", 32'(o_wrap[2]), 1);
        step(1); chk("t3.hold9b", 32'(o_out2), 9);
        chk("t3.wrap_b", 32'(o_wrap[2]), 1);
        up = 1'b0;
        step(1); chk("t3.down8", 32'(o_out2), 8);
        chk("t3.wrap_c", 32'(o_wrap[2]), 0);

        // Prescaler of 3: phase, stall, reload
        en = 1'b0; up = 1'b1; load = 1'b1; load_val = 8'd0;
        step(1);
        load = 1'b0; en = 1'b1;
        step(2); chk("t4.e2", 32'(o_out3), 0);
        step(1); chk("t4.e3", 32'(o_out3), 1);
        step(1);
        en = 1'b0;
        step(2); chk("t4.stall", 32'(o_out3), 1);
        en = 1'b1;
        step(1); chk("t4.e7", 32'(o_out3), 1);
        step(1); chk("t4.e8", 32'(o_out3), 2);
        step(1);
        load = 1'b1; load_val = 8'd5;
        step(1);
        load = 1'b0;
        step(2); chk("t4.phase", 32'(o_out3), 5);
        step(1); chk("t4.after", 32'(o_out3), 6);

        // Clamp, clear-over-load, reset-over-load
        en = 1'b0; load = 1'b1; load_val = 8'd200;
        step(1);
        chk("t5.clamp99", 32'(o_out3), 99);
        chk("t5.clamp9", 32'(o_out1), 8);
        clear = 1'b1; load_val = 8'd50;
        step(1);
        clear = 1'b0; load = 1'b0;
        chk("t5.clr_ld", 32'(o_out3), 0);
        en = 1'b1;
        step(5);
        chk("t5.count5", 32'(o_out0), 5);
        reset = 1'b1; load = 1'b1; load_val = 8'd77;
        step(1);
        chk("t5.rst_out", 32'(o_out0), 0);
        chk("t5.rst_ovf", 32'(o_ovf[0]), 0);
        reset = 1'b0; load = 1'b0;

        // ovf_clr alone, then colliding with a wrap event
        en = 1'b0; up = 1'b1; load = 1'b1; load_val = 8'd9;
        step(1);
        load = 1'b0; en = 1'b1;
        step(1);
        chk("t6.ovf_set", 32'(o_ovf[1]), 1);
        en = 1'b0; ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("t6.ovf_clr", 32'(o_ovf[1]), 0);
        load = 1'b1;
        step(1);
        load = 1'b0; en = 1'b1; ovf_clr = 1'b1;
        step(1);
        chk("t6.set_wins", 32'(o_ovf[1]), 1);
        chk("t6.wrap", 32'(o_wrap[1]), 1);
        ovf_clr = 1'b0;

        // Random traffic
        repeat (4000) begin
            reset = ($urandom_range(0, 199) == 0);
            clear = ($urandom_range(0, 29) == 0);
            load = ($urandom_range(0, 14) == 0);
            load_val = 8'($urandom);
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) up = ~up;
            ovf_clr = !clear && !load && ($urandom_range(0, 9) == 0);
            step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
